// File: rtl/cnn_pool_pkg.sv
// Shared types and helpers for the CNN max-pool stages.
package cnn_pool_pkg;

    localparam int DW = 20;

    typedef logic signed [DW-1:0] pix_t;

    typedef enum logic {
        ROW_EVEN = 1'b0,
        ROW_ODD  = 1'b1
    } pool_state_t;

    // Signed maximum of two pixels; ties return b, which equals a anyway.
    function automatic pix_t smax(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One-row buffer of horizontal partial maxima, one entry per pooled column.
module pool_line_buf
    import cnn_pool_pkg::*;
#(
    parameter int DEPTH = 13,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    input  pix_t          wr_data,
    output pix_t          rd_data
);

    pix_t mem [DEPTH];

    // Contents are never reset: every entry is rewritten on an even row before it is read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/cnn_maxpool1_stream.sv
// 2x2 stride-2 streaming max-pool using a single row of partial maxima.
module cnn_maxpool1_stream #(
    parameter int DW    = 20,
    parameter int IMG_W = 26,
    parameter int IMG_H = 26
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic                 out_last,
    output logic                 frame_err
);

    import cnn_pool_pkg::*;

    localparam int CW       = (IMG_W > 2) ? $clog2(IMG_W) : 2;
    localparam int RW       = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int AW       = CW - 1;
    localparam int LB_DEPTH = IMG_W / 2;

    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    if ((IMG_W % 2) != 0) begin : g_bad_width
        $fatal(1, "cnn_maxpool1_stream: IMG_W must be even");
    end
    if ((IMG_H % 2) != 0) begin : g_bad_height
        $fatal(1, "cnn_maxpool1_stream: IMG_H must be even");
    end
    if (DW != $bits(pix_t)) begin : g_bad_dw
        $fatal(1, "cnn_maxpool1_stream: DW must match cnn_pool_pkg::DW");
    end

    pool_state_t   state, state_next;
    logic [CW-1:0] col, col_next;
    logic [RW-1:0] row, row_next;
    pix_t          hold;
    pix_t          in_pix;
    pix_t          pair_max;
    pix_t          lb_rd;

    logic accept;
    logic col_last;
    logic at_final;
    logic hold_en;
    logic lb_we;
    logic out_load;
    logic out_last_next;
    logic frame_err_next;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign in_pix   = pix_t'(in_data);
    assign pair_max = smax(hold, in_pix);
    assign col_last = (col == COL_MAX);
    assign at_final = col_last && (row == ROW_MAX);

    pool_line_buf #(
        .DEPTH (LB_DEPTH),
        .AW    (AW)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (lb_we),
        .addr    (col[CW-1:1]),
        .wr_data (pair_max),
        .rd_data (lb_rd)
    );

    // Next-state, counter advance and per-beat datapath enables for the accepted pixel.
    always_comb begin
        state_next     = state;
        col_next       = col;
        row_next       = row;
        hold_en        = 1'b0;
        lb_we          = 1'b0;
        out_load       = 1'b0;
        out_last_next  = 1'b0;
        frame_err_next = 1'b0;

        if (accept) begin
            if (in_last && !at_final) begin
                frame_err_next = 1'b1;
                col_next       = '0;
                row_next       = '0;
                state_next     = ROW_EVEN;
            end else begin
                frame_err_next = at_final && !in_last;
                hold_en        = !col[0];
                lb_we          = col[0] && (state == ROW_EVEN);
                out_load       = col[0] && (state == ROW_ODD);
                out_last_next  = at_final;
                if (col_last) begin
                    col_next = '0;
                    if (row == ROW_MAX) begin
                        row_next   = '0;
                        state_next = ROW_EVEN;
                    end else begin
                        row_next   = row + 1'b1;
                        state_next = (state == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
                    end
                end else begin
                    col_next = col + 1'b1;
                end
            end
        end
    end

    // Position counters and row-parity state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ROW_EVEN;
            col   <= '0;
            row   <= '0;
        end else begin
            state <= state_next;
            col   <= col_next;
            row   <= row_next;
        end
    end

    // Left pixel of the current horizontal pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold <= '0;
        end else if (hold_en) begin
            hold <= in_pix;
        end
    end

    // Output register: loads a finished window, otherwise drains on a downstream handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (out_load) begin
            out_valid <= 1'b1;
            out_data  <= smax(lb_rd, pair_max);
            out_last  <= out_last_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Single-cycle pulse when in_last disagrees with the expected frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= frame_err_next;
        end
    end

endmodule

// File: tb/tb_cnn_maxpool1_stream.sv
// Self-checking bench for the streaming 2x2 max-pool stage.
module tb_cnn_maxpool1_stream;

    localparam int DW    = 20;
    localparam int IMG_W = 26;
    localparam int IMG_H = 26;
    localparam int OUT_W = IMG_W / 2;
    localparam int OUT_H = IMG_H / 2;
    localparam int OUT_N = OUT_W * OUT_H;

    typedef struct {
        logic signed [DW-1:0] data;
        logic                 last;
    } beat_t;

    typedef struct {
        string name;
        int    p00;
        int    p01;
        int    p10;
        int    p11;
        int    expected;
    } winVec_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] in_data = '0;
    logic                 in_last = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [DW-1:0] out_data;
    logic                 out_last;
    logic                 frame_err;

    int    testCount = 0;
    int    failCount = 0;
    int    errCount  = 0;
    int    errBase   = 0;
    int    readyMode = 0;
    int    frame [IMG_H][IMG_W];
    beat_t expQ [$];
    beat_t gotQ [$];
    beat_t monBeat;
    winVec_t vecs [6];

    cnn_maxpool1_stream #(
        .DW    (DW),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Downstream ready: always on, random, or held low, updated just after each edge.
    always begin
        @(posedge clk);
        #2;
        case (readyMode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Record every output handshake and every frame_err cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                monBeat.data = out_data;
                monBeat.last = out_last;
                gotQ.push_back(monBeat);
            end
            if (frame_err) begin
                errCount = errCount + 1;
            end
        end
    end

    // Hard stop if something hangs beyond every bounded wait.
    initial begin
        #3000000;
        $display("[TB] FAIL global_timeout: simulation time exceeded, got no finish, wanted finish");
        failCount = failCount + 1;
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        testCount = testCount + 1;
        if (actual != expected) begin
            failCount = failCount + 1;
            $display("[TB] FAIL %s: got %0d, wanted %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [DW-1:0] d, input logic l);
        int waitCnt;
        waitCnt  = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && waitCnt < 1000) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", longint'(in_ready), 1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic sendFrame(input bit gaps, input bit withLast);
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                if (gaps && ($urandom_range(0, 3) == 0)) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
                applyStimulus(DW'(frame[r][c]),
                              withLast && (r == IMG_H - 1) && (c == IMG_W - 1));
            end
        end
    endtask

    task automatic fillRamp();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                frame[r][c] = r * IMG_W + c;
    endtask

    task automatic fillRandom();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                frame[r][c] = int'($urandom_range(0, (1 << DW) - 1)) - (1 << (DW - 1));
    endtask

    task automatic fillPattern(input winVec_t v);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                frame[r][c] = (r % 2 == 0) ? ((c % 2 == 0) ? v.p00 : v.p01)
                                           : ((c % 2 == 0) ? v.p10 : v.p11);
    endtask

    task automatic pushExpected(input int value, input bit last);
        beat_t b;
        b.data = DW'(value);
        b.last = last;
        expQ.push_back(b);
    endtask

    // Ramp outputs follow directly from the ramp formula: bottom-right pixel of each window.
    task automatic pushRampExpected(input int count);
        for (int k = 0; k < count; k++) begin
            pushExpected((2 * (k / OUT_W) + 1) * IMG_W + 2 * (k % OUT_W) + 1, k == OUT_N - 1);
        end
    endtask

    // Reference max-pool of the whole stored frame.
    task automatic modelPool();
        int m;
        for (int i = 0; i < OUT_H; i++) begin
            for (int j = 0; j < OUT_W; j++) begin
                m = frame[2*i][2*j];
                if (frame[2*i][2*j+1]   > m) m = frame[2*i][2*j+1];
                if (frame[2*i+1][2*j]   > m) m = frame[2*i+1][2*j];
                if (frame[2*i+1][2*j+1] > m) m = frame[2*i+1][2*j+1];
                pushExpected(m, (i == OUT_H - 1) && (j == OUT_W - 1));
            end
        end
    endtask

    task automatic checkStream(input string name);
        int waited;
        waited = 0;
        while (gotQ.size() < expQ.size() && waited < 5000) begin
            @(posedge clk);
            waited++;
        end
        repeat (4) @(posedge clk);
        #1;
        checkOutput($sformatf("%s.count", name), longint'(gotQ.size()), longint'(expQ.size()));
        for (int k = 0; k < expQ.size() && k < gotQ.size(); k++) begin
            checkOutput($sformatf("%s[%0d].data", name, k),
                        longint'(gotQ[k].data), longint'(expQ[k].data));
            checkOutput($sformatf("%s[%0d].last", name, k),
                        longint'(gotQ[k].last), longint'(expQ[k].last));
        end
        gotQ.delete();
        expQ.delete();
    endtask

    initial begin : main
        logic signed [DW-1:0] held;
        int waitCnt;

        vecs[0] = '{"mixed_sign",  -5,       3,       -7,      2,       3};
        vecs[1] = '{"all_neg",     -5,      -3,       -7,     -2,      -2};
        vecs[2] = '{"all_zero",     0,       0,        0,      0,       0};
        vecs[3] = '{"extremes",     524287, -524288,   1,      0,  524287};
        vecs[4] = '{"most_neg",    -524288, -524288, -524288, -524287, -524287};
        vecs[5] = '{"ties",         7,       7,        7,      7,       7};

        // Reset values
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.out_valid", longint'(out_valid), 0);
        checkOutput("reset.out_data",  longint'(out_data), 0);
        checkOutput("reset.out_last",  longint'(out_last), 0);
        checkOutput("reset.frame_err", longint'(frame_err), 0);
        rst = 1'b0;
        #1;
        checkOutput("reset.in_ready",  longint'(in_ready), 1);
        @(posedge clk);
        #1;

        // Table of uniform window patterns: every pooled pixel equals the table value
        for (int v = 0; v < 6; v++) begin
            fillPattern(vecs[v]);
            for (int k = 0; k < OUT_N; k++) pushExpected(vecs[v].expected, k == OUT_N - 1);
            sendFrame(1'b0, 1'b1);
            checkStream(vecs[v].name);
        end

        // Plain ramp at full rate
        errBase = errCount;
        fillRamp();
        pushRampExpected(OUT_N);
        sendFrame(1'b0, 1'b1);
        checkStream("ramp");
        checkOutput("ramp.frame_err", longint'(errCount - errBase), 0);

        // Backpressure right after the first pooled pixel
        readyMode = 2;
        @(posedge clk);
        #3;
        fillRamp();
        pushRampExpected(OUT_N);
        fork
            sendFrame(1'b0, 1'b1);
            begin
                waitCnt = 0;
                @(negedge clk);
                while (!out_valid && waitCnt < 200) begin
                    @(negedge clk);
                    waitCnt++;
                end
                checkOutput("bp.first_valid", longint'(out_valid), 1);
                held = out_data;
                checkOutput("bp.first_data", longint'(held), IMG_W + 1);
                for (int k = 0; k < 10; k++) begin
                    checkOutput("bp.hold_valid", longint'(out_valid), 1);
                    checkOutput("bp.hold_data",  longint'(out_data), longint'(held));
                    checkOutput("bp.in_ready",   longint'(in_ready), 0);
                    @(negedge clk);
                end
                readyMode = 0;
            end
        join
        checkStream("backpressure");

        // Frame end reached without in_last: error pulse, outputs still complete
        errBase = errCount;
        fillRamp();
        pushRampExpected(OUT_N);
        sendFrame(1'b0, 1'b0);
        checkStream("missing_last");
        checkOutput("missing_last.frame_err", longint'(errCount - errBase), 1);

        // Early in_last at pixel 100 (row 3, col 22): partial outputs then resync
        errBase = errCount;
        for (int idx = 0; idx <= 100; idx++) begin
            applyStimulus(DW'(idx), idx == 100);
        end
        pushRampExpected(OUT_W + 11);
        checkStream("early_last");
        checkOutput("early_last.frame_err", longint'(errCount - errBase), 1);
        fillRamp();
        pushRampExpected(OUT_N);
        sendFrame(1'b0, 1'b1);
        checkStream("early_last_recover");
        checkOutput("early_last_recover.frame_err", longint'(errCount - errBase), 1);

        // Reset in the middle of row 7 while a pooled pixel is pending
        errBase = errCount;
        for (int idx = 0; idx < 7 * IMG_W + 10; idx++) begin
            applyStimulus(DW'(idx), 1'b0);
        end
        readyMode = 2;
        checkOutput("mid_rst.pending_valid", longint'(out_valid), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid_rst.out_valid", longint'(out_valid), 0);
        checkOutput("mid_rst.out_last",  longint'(out_last), 0);
        rst = 1'b0;
        readyMode = 0;
        pushRampExpected(3 * OUT_W + 4);
        checkStream("mid_rst_partial");
        fillRamp();
        pushRampExpected(OUT_N);
        sendFrame(1'b0, 1'b1);
        checkStream("mid_rst_fresh");
        checkOutput("mid_rst.frame_err", longint'(errCount - errBase), 0);

        // Three back-to-back random frames with random gaps on both sides
        errBase = errCount;
        readyMode = 1;
        for (int f = 0; f < 3; f++) begin
            fillRandom();
            modelPool();
            sendFrame(1'b1, 1'b1);
        end
        checkStream("random");
        readyMode = 0;
        checkOutput("random.frame_err", longint'(errCount - errBase), 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
